// File: rtl/sfu_commit_gather_if.sv
// Commit bus between the SFU response arbiter and the per-issue-slot commit ports.
// The slave modport is the gather block; the master side drives packets and slot readiness.
interface sfu_commit_gather_if #(
  parameter int ISSUE_CNT  = 4,
  parameter int WARP_CNT   = 8,
  parameter int THREAD_CNT = 4,
  parameter int NUM_LANES  = 2,
  parameter int XLEN       = 32,
  parameter int UUID_W     = 44
);
  localparam int WID_W = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1;
  localparam int WIS_W = ((WARP_CNT / ISSUE_CNT) > 1) ? $clog2(WARP_CNT / ISSUE_CNT) : 1;
  localparam int PID_W = ((THREAD_CNT / NUM_LANES) > 1) ? $clog2(THREAD_CNT / NUM_LANES) : 1;

  // valid/ready: a transfer happens on a rising clk edge where valid && ready;
  // valid never depends on ready, and a held payload stays stable until it transfers.
  logic                             in_valid;
  logic                             in_ready;
  logic [UUID_W-1:0]                in_uuid;
  logic [WID_W-1:0]                 in_wid;
  logic [NUM_LANES-1:0]             in_tmask;
  logic [NUM_LANES*XLEN-1:0]        in_data;
  logic [4:0]                       in_rd;
  logic                             in_wb;
  logic [XLEN-1:0]                  in_pc;
  logic [PID_W-1:0]                 in_pid;
  logic                             in_sop;
  logic                             in_eop;

  logic [ISSUE_CNT-1:0]             out_valid;
  logic [ISSUE_CNT-1:0]             out_ready;
  logic [ISSUE_CNT*UUID_W-1:0]      out_uuid;
  logic [ISSUE_CNT*WIS_W-1:0]       out_wis;
  logic [ISSUE_CNT*THREAD_CNT-1:0]  out_tmask;
  logic [ISSUE_CNT*THREAD_CNT*XLEN-1:0] out_data;
  logic [ISSUE_CNT*5-1:0]           out_rd;
  logic [ISSUE_CNT-1:0]             out_wb;
  logic [ISSUE_CNT*XLEN-1:0]        out_pc;
  logic [ISSUE_CNT-1:0]             out_sop;
  logic [ISSUE_CNT-1:0]             out_eop;

  modport slave (
    input  in_valid, in_uuid, in_wid, in_tmask, in_data, in_rd, in_wb, in_pc,
           in_pid, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_uuid, out_wis, out_tmask, out_data, out_rd,
           out_wb, out_pc, out_sop, out_eop
  );

  modport master (
    output in_valid, in_uuid, in_wid, in_tmask, in_data, in_rd, in_wb, in_pc,
           in_pid, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_uuid, out_wis, out_tmask, out_data, out_rd,
           out_wb, out_pc, out_sop, out_eop
  );
endinterface

// File: rtl/sfu_commit_gather.sv
// Routes the arbitrated SFU commit stream to per-issue-slot ports through 2-entry buffers,
// expanding each PID packet to full warp width. SFU_GATHER_PERF_EN adds the perf_stalls counter.
module sfu_commit_gather #(
  parameter int ISSUE_CNT  = 4,
  parameter int WARP_CNT   = 8,
  parameter int THREAD_CNT = 4,
  parameter int NUM_LANES  = 2,
  parameter int XLEN       = 32,
  parameter int UUID_W     = 44,
  parameter int PERF_W     = 44
) (
  input  logic clk,
  input  logic reset,
  sfu_commit_gather_if.slave bus
`ifdef SFU_GATHER_PERF_EN
  ,output logic [PERF_W-1:0] perf_stalls
`endif
);
  localparam int ISW_SH = $clog2(ISSUE_CNT);
  localparam int ISW    = (ISW_SH > 0) ? ISW_SH : 1;
  localparam int WIS_W  = ((WARP_CNT / ISSUE_CNT) > 1) ? $clog2(WARP_CNT / ISSUE_CNT) : 1;
  localparam int PKTS   = THREAD_CNT / NUM_LANES;

  typedef struct packed {
    logic [UUID_W-1:0]          uuid;
    logic [WIS_W-1:0]           wis;
    logic [THREAD_CNT-1:0]      tmask;
    logic [THREAD_CNT*XLEN-1:0] data;
    logic [4:0]                 rd;
    logic                       wb;
    logic [XLEN-1:0]            pc;
    logic                       sop;
    logic                       eop;
  } entry_t;

  entry_t     mem_q [ISSUE_CNT][2];
  logic       wr_q  [ISSUE_CNT];
  logic       rd_q  [ISSUE_CNT];
  logic [1:0] cnt_q [ISSUE_CNT];

  logic [ISW-1:0]       isel;
  logic                 in_fire;
  logic [ISSUE_CNT-1:0] push_s;
  logic [ISSUE_CNT-1:0] pop_s;
  entry_t               new_entry;
  int                   lane_off;

  if (ISSUE_CNT == 1) begin : g_one_slot
    assign isel = '0;
  end else begin : g_multi_slot
    assign isel = bus.in_wid[ISW-1:0];
  end

  // in_ready looks only at the registered occupancy, so a full slot stays closed even while it pops.
  assign bus.in_ready = (cnt_q[isel] != 2'd2);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    lane_off = 0;
    if (PKTS > 1) lane_off = NUM_LANES * int'(bus.in_pid);
    new_entry       = '0;
    new_entry.uuid  = bus.in_uuid;
    new_entry.wis   = WIS_W'(bus.in_wid >> ISW_SH);
    new_entry.tmask = THREAD_CNT'(bus.in_tmask) << lane_off;
    new_entry.data  = (THREAD_CNT*XLEN)'(bus.in_data) << (lane_off * XLEN);
    new_entry.rd    = bus.in_rd;
    new_entry.wb    = bus.in_wb;
    new_entry.pc    = bus.in_pc;
    new_entry.sop   = bus.in_sop;
    new_entry.eop   = bus.in_eop;
  end

  always_comb begin
    push_s = '0;
    pop_s  = '0;
    for (int s = 0; s < ISSUE_CNT; s++) begin
      push_s[s] = in_fire && (isel == ISW'(s));
      pop_s[s]  = (cnt_q[s] != 2'd0) && bus.out_ready[s];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < ISSUE_CNT; s++) begin
        cnt_q[s]    <= 2'd0;
        wr_q[s]     <= 1'b0;
        rd_q[s]     <= 1'b0;
        mem_q[s][0] <= '0;
        mem_q[s][1] <= '0;
      end
    end else begin
      for (int s = 0; s < ISSUE_CNT; s++) begin
        if (push_s[s]) begin
          mem_q[s][wr_q[s]] <= new_entry;
          wr_q[s]           <= ~wr_q[s];
        end
        if (pop_s[s]) rd_q[s] <= ~rd_q[s];
        cnt_q[s] <= cnt_q[s] + 2'(push_s[s]) - 2'(pop_s[s]);
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_uuid  = '0;
    bus.out_wis   = '0;
    bus.out_tmask = '0;
    bus.out_data  = '0;
    bus.out_rd    = '0;
    bus.out_wb    = '0;
    bus.out_pc    = '0;
    bus.out_sop   = '0;
    bus.out_eop   = '0;
    for (int s = 0; s < ISSUE_CNT; s++) begin
      bus.out_valid[s]                                    = (cnt_q[s] != 2'd0);
      bus.out_uuid[s*UUID_W +: UUID_W]                    = mem_q[s][rd_q[s]].uuid;
      bus.out_wis[s*WIS_W +: WIS_W]                       = mem_q[s][rd_q[s]].wis;
      bus.out_tmask[s*THREAD_CNT +: THREAD_CNT]           = mem_q[s][rd_q[s]].tmask;
      bus.out_data[s*THREAD_CNT*XLEN +: THREAD_CNT*XLEN]  = mem_q[s][rd_q[s]].data;
      bus.out_rd[s*5 +: 5]                                = mem_q[s][rd_q[s]].rd;
      bus.out_wb[s]                                       = mem_q[s][rd_q[s]].wb;
      bus.out_pc[s*XLEN +: XLEN]                          = mem_q[s][rd_q[s]].pc;
      bus.out_sop[s]                                      = mem_q[s][rd_q[s]].sop;
      bus.out_eop[s]                                      = mem_q[s][rd_q[s]].eop;
    end
  end

`ifdef SFU_GATHER_PERF_EN
  logic [PERF_W-1:0] perf_q;
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else if (bus.in_valid && !bus.in_ready) perf_q <= perf_q + 1'b1;
  end
  assign perf_stalls = perf_q;
`endif

endmodule

// File: tb/tb_sfu_commit_gather.sv
// Bench for sfu_commit_gather: directed scenarios then random traffic, checked each cycle
// against per-slot expected queues built from the packet expansion rules.
module tb_sfu_commit_gather;
  localparam int ISSUE_CNT  = 4;
  localparam int WARP_CNT   = 8;
  localparam int THREAD_CNT = 4;
  localparam int NUM_LANES  = 2;
  localparam int XLEN       = 32;
  localparam int UUID_W     = 44;
  localparam int PERF_W     = 44;
  localparam int WID_W      = 3;
  localparam int WIS_W      = 1;
  localparam int EW = UUID_W + WIS_W + THREAD_CNT + THREAD_CNT*XLEN + 5 + 1 + XLEN + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfu_commit_gather_if #(
    .ISSUE_CNT(ISSUE_CNT), .WARP_CNT(WARP_CNT), .THREAD_CNT(THREAD_CNT),
    .NUM_LANES(NUM_LANES), .XLEN(XLEN), .UUID_W(UUID_W)
  ) bus ();

`ifdef SFU_GATHER_PERF_EN
  logic [PERF_W-1:0] perf_stalls;
`endif

  sfu_commit_gather #(
    .ISSUE_CNT(ISSUE_CNT), .WARP_CNT(WARP_CNT), .THREAD_CNT(THREAD_CNT),
    .NUM_LANES(NUM_LANES), .XLEN(XLEN), .UUID_W(UUID_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef SFU_GATHER_PERF_EN
    ,.perf_stalls(perf_stalls)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0]     exp_q [ISSUE_CNT][$];
  logic [PERF_W-1:0] exp_perf;
  logic              last_push;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] make_exp(
    input logic [WID_W-1:0] wid, input logic pid, input logic [NUM_LANES-1:0] tm,
    input logic [NUM_LANES*XLEN-1:0] d, input logic [UUID_W-1:0] uuid, input logic [4:0] rd,
    input logic wb, input logic [XLEN-1:0] pc, input logic sop, input logic eop);
    logic [THREAD_CNT-1:0]      etm;
    logic [THREAD_CNT*XLEN-1:0] ed;
    logic [WID_W-1:0]           wis;
    etm = '0;
    ed  = '0;
    for (int t = 0; t < THREAD_CNT; t++) begin
      if (t / NUM_LANES == int'(pid)) begin
        etm[t]            = tm[t % NUM_LANES];
        ed[t*XLEN +: XLEN] = d[(t % NUM_LANES)*XLEN +: XLEN];
      end
    end
    wis = wid / ISSUE_CNT;
    return {uuid, wis[WIS_W-1:0], etm, ed, rd, wb, pc, sop, eop};
  endfunction

  function automatic logic [EW-1:0] obs_slot(input int s);
    return {bus.out_uuid[s*UUID_W +: UUID_W], bus.out_wis[s*WIS_W +: WIS_W],
            bus.out_tmask[s*THREAD_CNT +: THREAD_CNT],
            bus.out_data[s*THREAD_CNT*XLEN +: THREAD_CNT*XLEN], bus.out_rd[s*5 +: 5],
            bus.out_wb[s], bus.out_pc[s*XLEN +: XLEN], bus.out_sop[s], bus.out_eop[s]};
  endfunction

  // Reference: each slot is a queue of at most two packets; readiness is judged before pops.
  task automatic model_clock();
    int  sel;
    bit  rdy;
    last_push = 1'b0;
    if (reset) begin
      for (int s = 0; s < ISSUE_CNT; s++) exp_q[s].delete();
      exp_perf = '0;
      return;
    end
    sel = int'(bus.in_wid) % ISSUE_CNT;
    rdy = exp_q[sel].size() < 2;
    for (int s = 0; s < ISSUE_CNT; s++)
      if (exp_q[s].size() != 0 && bus.out_ready[s]) void'(exp_q[s].pop_front());
    if (bus.in_valid && rdy) begin
      exp_q[sel].push_back(make_exp(bus.in_wid, bus.in_pid, bus.in_tmask, bus.in_data,
                                    bus.in_uuid, bus.in_rd, bus.in_wb, bus.in_pc,
                                    bus.in_sop, bus.in_eop));
      last_push = 1'b1;
    end
    if (bus.in_valid && !rdy) exp_perf = exp_perf + 1'b1;
  endtask

  task automatic check_cycle();
    logic [ISSUE_CNT-1:0] ev;
    int sel;
    sel = int'(bus.in_wid) % ISSUE_CNT;
    check("in_ready", 256'(bus.in_ready), 256'(exp_q[sel].size() < 2));
    ev = '0;
    for (int s = 0; s < ISSUE_CNT; s++) ev[s] = exp_q[s].size() != 0;
    check("out_valid", 256'(bus.out_valid), 256'(ev));
    for (int s = 0; s < ISSUE_CNT; s++)
      if (exp_q[s].size() != 0) check($sformatf("head%0d", s), 256'(obs_slot(s)), 256'(exp_q[s][0]));
`ifdef SFU_GATHER_PERF_EN
    check("perf_stalls", 256'(perf_stalls), 256'(exp_perf));
`endif
  endtask

  task automatic finish_cycle();
    check_cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic set_pkt(input logic [WID_W-1:0] wid, input logic pid, input logic [1:0] tm,
                         input logic [63:0] d, input logic sop, input logic eop,
                         input logic [UUID_W-1:0] uuid);
    bus.in_valid = 1'b1;
    bus.in_wid   = wid;
    bus.in_pid   = pid;
    bus.in_tmask = tm;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_uuid  = uuid;
    bus.in_rd    = 5'(uuid);
    bus.in_wb    = uuid[0];
    bus.in_pc    = 32'h1000 + 32'(uuid[7:0]);
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = '1;
    set_pkt(3'd0, 1'b0, 2'b00, 64'd0, 1'b0, 1'b0, 44'd0);
    set_idle();
    exp_perf = '0;
    repeat (2) begin
      @(posedge clk);
      model_clock();
    end
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 256'(bus.out_valid), 256'(4'b0000));
    check("rst_in_ready", 256'(bus.in_ready), 256'(1'b1));
    finish_cycle();

    // Single packet: wid 5, pid 1
    set_pkt(3'd5, 1'b1, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 1'b1, 1'b1, 44'h123);
    cycle();
    set_idle();
    @(negedge clk);
    check("single_valid", 256'(bus.out_valid), 256'(4'b0010));
    check("single_tmask", 256'(bus.out_tmask[7:4]), 256'(4'b1100));
    check("single_data", 256'(bus.out_data[255:128]),
          256'({32'hBBBB_0002, 32'hAAAA_0001, 64'd0}));
    check("single_wis", 256'(bus.out_wis[1]), 256'(1'b1));
    finish_cycle();

    // Split instruction to slot 0
    set_pkt(3'd0, 1'b0, 2'b11, {32'd11, 32'd10}, 1'b1, 1'b0, 44'h200);
    cycle();
    set_pkt(3'd0, 1'b1, 2'b11, {32'd13, 32'd12}, 1'b0, 1'b1, 44'h200);
    @(negedge clk);
    check("split_tm0", 256'(bus.out_tmask[3:0]), 256'(4'b0011));
    finish_cycle();
    set_idle();
    @(negedge clk);
    check("split_tm1", 256'(bus.out_tmask[3:0]), 256'(4'b1100));
    check("split_eop", 256'(bus.out_eop[0]), 256'(1'b1));
    finish_cycle();
    cycle();

    // Backpressure on slot 2, isolation on slot 3
    bus.out_ready = 4'b1011;
    set_pkt(3'd2, 1'b0, 2'b01, 64'h1, 1'b1, 1'b0, 44'h301);
    cycle();
    set_pkt(3'd2, 1'b1, 2'b10, 64'h2, 1'b0, 1'b0, 44'h302);
    cycle();
    set_pkt(3'd2, 1'b0, 2'b11, 64'h3, 1'b0, 1'b1, 44'h303);
    @(negedge clk);
    check("bp_blocked", 256'(bus.in_ready), 256'(1'b0));
    finish_cycle();
    cycle();
    set_pkt(3'd3, 1'b0, 2'b11, 64'h4, 1'b1, 1'b1, 44'h304);
    @(negedge clk);
    check("iso_ready", 256'(bus.in_ready), 256'(1'b1));
    finish_cycle();
    set_idle();
    @(negedge clk);
    check("iso_valid", 256'(bus.out_valid[3]), 256'(1'b1));
    finish_cycle();
    bus.out_ready = 4'b1111;
    set_pkt(3'd2, 1'b0, 2'b11, 64'h3, 1'b0, 1'b1, 44'h303);
    @(negedge clk);
    check("bp_full_pop", 256'(bus.in_ready), 256'(1'b0));
    finish_cycle();
    @(negedge clk);
    check("bp_reopen", 256'(bus.in_ready), 256'(1'b1));
    finish_cycle();
    set_idle();
    repeat (3) cycle();

    // Back-to-back stream through slot 0
    for (int i = 0; i < 8; i++) begin
      set_pkt(3'd4, 1'(i), 2'($urandom_range(0, 3)), {$urandom, $urandom}, i[0] == 0, i[0] == 1,
              44'h400 + 44'(i));
      @(negedge clk);
      check("stream_ready", 256'(bus.in_ready), 256'(1'b1));
      finish_cycle();
    end
    set_idle();
    repeat (2) cycle();

    // Reset with slots 0 and 1 full
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      set_pkt(3'(i % 2), 1'b0, 2'b11, {$urandom, $urandom}, 1'b1, 1'b1, 44'h500 + 44'(i));
      cycle();
    end
    set_pkt(3'd1, 1'b0, 2'b11, 64'h9, 1'b1, 1'b1, 44'h599);
    cycle();
    set_idle();
    reset = 1'b1;
    cycle();
    @(negedge clk);
    check("rst_mid_valid", 256'(bus.out_valid), 256'(4'b0000));
    finish_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 256'(bus.in_ready), 256'(1'b1));
    finish_cycle();
    bus.out_ready = 4'b1111;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) != 0)
        set_pkt(3'($urandom_range(0, WARP_CNT - 1)), 1'($urandom), 2'($urandom),
                {$urandom, $urandom}, 1'($urandom), 1'($urandom), {12'($urandom), 32'($urandom)});
      else
        set_idle();
      bus.out_ready = 4'($urandom);
      cycle();
    end
    reset = 1'b0;
    set_idle();
    bus.out_ready = 4'b1111;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
